dcache_mem_arbiter: RTL and testbench
=====================================

Name: dcache_mem_arbiter

Overview:
- Shares NUM_CHANNELS memory-controller channels among the dcache's NUM_CONSUMERS per-lane fill and writeback request ports.
- Sits between the dcache `controller_*` side and the global memory.
- Each channel runs an independent request/relay FSM.
- Idle channels pick requesters round-robin, and the block completes the dcache's valid/ready/ack handshake.

Parameters:
ADDR_BITS, 8, memory address width
DATA_BITS, 8, memory data width
NUM_CONSUMERS, 8, dcache request lanes
NUM_CHANNELS, 2, memory channels (1..NUM_CONSUMERS)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
req_read_valid  in  NUM_CONSUMERS  dcache fill request per lane
req_read_address  in  ADDR_BITS x NUM_CONSUMERS  fill address
req_read_ready  out  NUM_CONSUMERS  fill data valid, held until req_read_valid drops
req_read_data  out  DATA_BITS x NUM_CONSUMERS  fill data
req_write_valid  in  NUM_CONSUMERS  dcache writeback request per lane
req_write_address  in  ADDR_BITS x NUM_CONSUMERS  writeback address
req_write_data  in  DATA_BITS x NUM_CONSUMERS  writeback data
req_write_ready  out  NUM_CONSUMERS  writeback done, held until req_write_valid drops
mem_read_valid  out  NUM_CHANNELS  channel read request
mem_read_address  out  ADDR_BITS x NUM_CHANNELS  channel read address
mem_read_ready  in  NUM_CHANNELS  memory read complete
mem_read_data  in  DATA_BITS x NUM_CHANNELS  memory read data
mem_write_valid  out  NUM_CHANNELS  channel write request
mem_write_address  out  ADDR_BITS x NUM_CHANNELS  channel write address
mem_write_data  out  DATA_BITS x NUM_CHANNELS  channel write data
mem_write_ready  in  NUM_CHANNELS  memory write complete

Behaviour:
- Reset:
  - All outputs are 0; all channels go to IDLE.
  - Ownership mask, per-channel owner ids and rr_ptr are cleared to 0.
  - Reset asserted mid-transaction abandons it; no output glitches beyond the async clear.
- Per-channel states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- IDLE grant:
  - Scan lanes from rr_ptr upward, wrapping modulo NUM_CONSUMERS.
  - A lane is eligible when (read_valid | write_valid) is set, it is not owned, and it was not taken this cycle by a lower-indexed channel.
  - Channels are served in index order, so a single cycle can grant up to NUM_CHANNELS distinct lanes.
- Read has priority over write when both are valid on the same lane.
- On grant:
  - Record the owner and set its ownership bit.
  - Next cycle, mem_*_valid = 1 with the registered address (and data for writes).
  - Latency: 1 cycle from request to mem valid.
- READ_WAIT:
  - mem_read_valid held until mem_read_ready.
  - Then capture mem_read_data, set mem_read_valid = 0, set req_read_ready[owner] = 1 and req_read_data[owner] = captured data, and go to READ_RELAY.
- WRITE_WAIT: mem_write_valid held until mem_write_ready, then mem_write_valid = 0, req_write_ready[owner] = 1, go to WRITE_RELAY.
- Relay and release:
  - READ_RELAY / WRITE_RELAY hold the ready until the owner's valid is seen low.
  - Then clear the ready, clear the ownership bit and return to IDLE.
  - A released lane becomes eligible the following cycle at the earliest.
- Response path: memory completion to req ready takes 1 cycle.
- req_read_data holds its last value after ready drops; it is cleared only by reset.
- Valid dropped early: if a lane drops valid during a WAIT state, the memory transaction still completes (no abort). The resulting ready pulses exactly 1 cycle.
- rr_ptr:
  - Updates on any cycle with at least one grant, to (highest granted lane in scan order + 1) mod NUM_CONSUMERS.
  - Unchanged otherwise.
- Ownership invariant: a lane is never owned by two channels; no req_* ready is ever asserted for an unowned lane.
- Memory-side rule: mem_*_ready arriving in a state that does not expect it is ignored.

Optional Feature:
- Macro: DCACHE_ARB_STATS_EN.
- When defined, three 16-bit output counters are added:
  - stat_read_grants: increments per read grant.
  - stat_write_grants: increments per write grant.
  - stat_stall_cycles: increments each cycle in which an eligible lane exists but no channel is IDLE.
- Counter behaviour: saturate at 0xFFFF; reset to 0.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Single read: cycle 1 lane0 read 0xFF. Cycle 2: mem_read_valid[0] = 1, address 0xFF. Memory returns ready + 0xAB. Next cycle: req_read_ready[0] = 1, data 0xAB. Lane drops valid; the following cycle ready = 0 and channel 0 is IDLE.
- Dual grant: lane0 read 0xFF and lane1 write 0xF0/0xF0 in the same cycle. Next cycle: channel0 reads 0xFF, channel1 writes 0xF0 with data 0xF0. Both ready responses arrive independently.
- Contention: lanes 0, 3, 5 each read with NUM_CHANNELS = 2. Lanes 0 and 3 are granted first; lane 5 is granted only after a channel releases. rr_ptr = 4 after the first grant.
- Fairness: lanes 0 and 1 re-request continuously. Grants alternate 0, 1, 0, 1; no lane waits more than NUM_CONSUMERS/NUM_CHANNELS grant rounds.
- Same-lane read+write: lane2 has both valid. Read is served first; the write is served after read release.
- Reset mid-READ_WAIT: all outputs 0 within the same cycle. After deassert, a new lane4 read issues normally; a stale mem_read_ready is ignored.

Source files
------------

// File: rtl/dcache_mem_arbiter.sv
// Shares NUM_CHANNELS memory channels among NUM_CONSUMERS dcache fill/writeback lanes
// with round-robin grant and per-channel request/relay FSMs. Optional counters: DCACHE_ARB_STATS_EN.
module dcache_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           req_read_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] req_read_address,
    output logic [NUM_CONSUMERS-1:0]           req_read_ready,
    output logic [DATA_BITS*NUM_CONSUMERS-1:0] req_read_data,
    input  logic [NUM_CONSUMERS-1:0]           req_write_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] req_write_address,
    input  logic [DATA_BITS*NUM_CONSUMERS-1:0] req_write_data,
    output logic [NUM_CONSUMERS-1:0]           req_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [ADDR_BITS*NUM_CHANNELS-1:0]  mem_write_address,
    output logic [DATA_BITS*NUM_CHANNELS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
`ifdef DCACHE_ARB_STATS_EN
    ,
    output logic [15:0]                        stat_read_grants,
    output logic [15:0]                        stat_write_grants,
    output logic [15:0]                        stat_stall_cycles
`endif
);
    localparam int LANE_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY
    } chan_state_t;

    chan_state_t            state_reg [NUM_CHANNELS];
    chan_state_t            state_next[NUM_CHANNELS];
    logic [LANE_BITS-1:0]   owner_reg [NUM_CHANNELS];
    logic [LANE_BITS-1:0]   owner_next[NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   addr_reg  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   addr_next [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   wdata_reg [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   wdata_next[NUM_CHANNELS];
    logic [DATA_BITS-1:0]   rd_data_reg [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   rd_data_next[NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] owned_reg, owned_next;
    logic [NUM_CONSUMERS-1:0] rd_ready_reg, rd_ready_next;
    logic [NUM_CONSUMERS-1:0] wr_ready_reg, wr_ready_next;
    logic [LANE_BITS-1:0]     rr_ptr_reg, rr_ptr_next;
`ifdef DCACHE_ARB_STATS_EN
    logic [15:0] stat_rd_reg, stat_wr_reg, stat_stall_reg;
    logic [16:0] stat_rd_sum, stat_wr_sum;
    logic        stall_now;
`endif

    always_comb begin : grant_comb
        logic [NUM_CONSUMERS-1:0] taken;
        logic                     found;
        logic                     any_idle;
        int                       lane_int;
        int                       pick;
        int                       rd_cnt;
        int                       wr_cnt;
        taken         = owned_reg;
        owned_next    = owned_reg;
        rd_ready_next = rd_ready_reg;
        wr_ready_next = wr_ready_reg;
        rr_ptr_next   = rr_ptr_reg;
        any_idle      = 1'b0;
        rd_cnt        = 0;
        wr_cnt        = 0;
        found         = 1'b0;
        pick          = 0;
        lane_int      = 0;
        for (int l = 0; l < NUM_CONSUMERS; l++) begin
            rd_data_next[l] = rd_data_reg[l];
        end
        // Channels are visited in index order; 'taken' keeps a later channel off a lane
        // an earlier one grabbed this cycle.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_next[c] = state_reg[c];
            owner_next[c] = owner_reg[c];
            addr_next[c]  = addr_reg[c];
            wdata_next[c] = wdata_reg[c];
            found         = 1'b0;
            pick          = 0;
            case (state_reg[c])
                IDLE: begin
                    any_idle = 1'b1;
                    for (int i = 0; i < NUM_CONSUMERS; i++) begin
                        lane_int = int'(rr_ptr_reg) + i;
                        if (lane_int >= NUM_CONSUMERS) lane_int = lane_int - NUM_CONSUMERS;
                        if (!found && (req_read_valid[lane_int] || req_write_valid[lane_int])
                                   && !taken[lane_int]) begin
                            found = 1'b1;
                            pick  = lane_int;
                        end
                    end
                    if (found) begin
                        taken[pick]      = 1'b1;
                        owned_next[pick] = 1'b1;
                        owner_next[c]    = LANE_BITS'(pick);
                        rr_ptr_next      = (pick + 1 >= NUM_CONSUMERS) ? '0 : LANE_BITS'(pick + 1);
                        if (req_read_valid[pick]) begin
                            state_next[c] = READ_WAIT;
                            addr_next[c]  = req_read_address[pick*ADDR_BITS +: ADDR_BITS];
                            rd_cnt        = rd_cnt + 1;
                        end else begin
                            state_next[c] = WRITE_WAIT;
                            addr_next[c]  = req_write_address[pick*ADDR_BITS +: ADDR_BITS];
                            wdata_next[c] = req_write_data[pick*DATA_BITS +: DATA_BITS];
                            wr_cnt        = wr_cnt + 1;
                        end
                    end
                end
                READ_WAIT: if (mem_read_ready[c]) begin
                    rd_ready_next[owner_reg[c]] = 1'b1;
                    rd_data_next[owner_reg[c]]  = mem_read_data[c*DATA_BITS +: DATA_BITS];
                    state_next[c]               = READ_RELAY;
                end
                WRITE_WAIT: if (mem_write_ready[c]) begin
                    wr_ready_next[owner_reg[c]] = 1'b1;
                    state_next[c]               = WRITE_RELAY;
                end
                READ_RELAY: if (!req_read_valid[owner_reg[c]]) begin
                    rd_ready_next[owner_reg[c]] = 1'b0;
                    owned_next[owner_reg[c]]    = 1'b0;
                    state_next[c]               = IDLE;
                end
                WRITE_RELAY: if (!req_write_valid[owner_reg[c]]) begin
                    wr_ready_next[owner_reg[c]] = 1'b0;
                    owned_next[owner_reg[c]]    = 1'b0;
                    state_next[c]               = IDLE;
                end
                default: state_next[c] = IDLE;
            endcase
        end
`ifdef DCACHE_ARB_STATS_EN
        stat_rd_sum = {1'b0, stat_rd_reg} + 17'(rd_cnt);
        stat_wr_sum = {1'b0, stat_wr_reg} + 17'(wr_cnt);
        stall_now   = (|((req_read_valid | req_write_valid) & ~owned_reg)) && !any_idle;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owned_reg    <= '0;
            rd_ready_reg <= '0;
            wr_ready_reg <= '0;
            rr_ptr_reg   <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_reg[c] <= IDLE;
                owner_reg[c] <= '0;
                addr_reg[c]  <= '0;
                wdata_reg[c] <= '0;
            end
            for (int l = 0; l < NUM_CONSUMERS; l++) rd_data_reg[l] <= '0;
        end else begin
            owned_reg    <= owned_next;
            rd_ready_reg <= rd_ready_next;
            wr_ready_reg <= wr_ready_next;
            rr_ptr_reg   <= rr_ptr_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_reg[c] <= state_next[c];
                owner_reg[c] <= owner_next[c];
                addr_reg[c]  <= addr_next[c];
                wdata_reg[c] <= wdata_next[c];
            end
            for (int l = 0; l < NUM_CONSUMERS; l++) rd_data_reg[l] <= rd_data_next[l];
        end
    end

`ifdef DCACHE_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_rd_reg    <= '0;
            stat_wr_reg    <= '0;
            stat_stall_reg <= '0;
        end else begin
            stat_rd_reg <= stat_rd_sum[16] ? 16'hFFFF : stat_rd_sum[15:0];
            stat_wr_reg <= stat_wr_sum[16] ? 16'hFFFF : stat_wr_sum[15:0];
            if (stall_now && stat_stall_reg != 16'hFFFF) stat_stall_reg <= stat_stall_reg + 16'd1;
        end
    end
    assign stat_read_grants  = stat_rd_reg;
    assign stat_write_grants = stat_wr_reg;
    assign stat_stall_cycles = stat_stall_reg;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
            assign mem_read_valid[gi]                              = (state_reg[gi] == READ_WAIT);
            assign mem_write_valid[gi]                             = (state_reg[gi] == WRITE_WAIT);
            assign mem_read_address[gi*ADDR_BITS +: ADDR_BITS]     = addr_reg[gi];
            assign mem_write_address[gi*ADDR_BITS +: ADDR_BITS]    = addr_reg[gi];
            assign mem_write_data[gi*DATA_BITS +: DATA_BITS]       = wdata_reg[gi];
        end
        for (gi = 0; gi < NUM_CONSUMERS; gi++) begin : g_lane
            assign req_read_data[gi*DATA_BITS +: DATA_BITS] = rd_data_reg[gi];
        end
    endgenerate

    assign req_read_ready  = rd_ready_reg;
    assign req_write_ready = wr_ready_reg;
endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// Directed bench for dcache_mem_arbiter with default parameters (8 lanes, 2 channels, 8-bit).
module tb_dcache_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  req_read_valid = '0;
    logic [63:0] req_read_address = '0;
    logic [7:0]  req_read_ready;
    logic [63:0] req_read_data;
    logic [7:0]  req_write_valid = '0;
    logic [63:0] req_write_address = '0;
    logic [63:0] req_write_data = '0;
    logic [7:0]  req_write_ready;
    logic [1:0]  mem_read_valid;
    logic [15:0] mem_read_address;
    logic [1:0]  mem_read_ready = '0;
    logic [15:0] mem_read_data = '0;
    logic [1:0]  mem_write_valid;
    logic [15:0] mem_write_address;
    logic [15:0] mem_write_data;
    logic [1:0]  mem_write_ready = '0;
`ifdef DCACHE_ARB_STATS_EN
    logic [15:0] stat_read_grants, stat_write_grants, stat_stall_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dcache_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .req_read_valid(req_read_valid), .req_read_address(req_read_address),
        .req_read_ready(req_read_ready), .req_read_data(req_read_data),
        .req_write_valid(req_write_valid), .req_write_address(req_write_address),
        .req_write_data(req_write_data), .req_write_ready(req_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
`ifdef DCACHE_ARB_STATS_EN
        , .stat_read_grants(stat_read_grants), .stat_write_grants(stat_write_grants),
        .stat_stall_cycles(stat_stall_cycles)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_read_valid = '0; req_read_address = '0;
        req_write_valid = '0; req_write_address = '0; req_write_data = '0;
        mem_read_ready = '0; mem_read_data = '0; mem_write_ready = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic rd_req(input int lane, input logic v, input logic [7:0] a);
        req_read_valid[lane] = v;
        req_read_address[lane*8 +: 8] = a;
    endtask

    task automatic wr_req(input int lane, input logic v, input logic [7:0] a, input logic [7:0] d);
        req_write_valid[lane] = v;
        req_write_address[lane*8 +: 8] = a;
        req_write_data[lane*8 +: 8] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        vectors++;
        if ({mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_mem got %h want 0", {mem_read_valid, mem_write_valid, mem_read_address, mem_write_address, mem_write_data});
        end
        vectors++;
        if ({req_read_ready, req_write_ready, req_read_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_req got %h want 0", {req_read_ready, req_write_ready, req_read_data});
        end
        reset = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_single_read();
        do_reset();
        rd_req(0, 1'b1, 8'hFF);
        tick();
        vectors++;
        if (mem_read_valid !== 2'b01 || mem_read_address[7:0] !== 8'hFF) begin
            miscompares++;
            $display("FAIL single_issue got v=%b a=%h want v=01 a=ff", mem_read_valid, mem_read_address[7:0]);
        end
        mem_read_ready[0] = 1'b1; mem_read_data[7:0] = 8'hAB;
        tick();
        mem_read_ready = '0;
        vectors++;
        if (req_read_ready !== 8'h01 || req_read_data[7:0] !== 8'hAB || mem_read_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL single_resp got rdy=%b d=%h mv=%b want rdy=00000001 d=ab mv=00", req_read_ready, req_read_data[7:0], mem_read_valid);
        end
        rd_req(0, 1'b0, 8'hFF);
        tick();
        vectors++;
        if (req_read_ready !== 8'h00 || req_read_data[7:0] !== 8'hAB) begin
            miscompares++;
            $display("FAIL single_release got rdy=%b d=%h want rdy=0 d=ab", req_read_ready, req_read_data[7:0]);
        end
        $display("single_read: lane0 addr ff data ab");
    endtask

    task automatic test_dual_grant();
        do_reset();
        rd_req(0, 1'b1, 8'hFF);
        wr_req(1, 1'b1, 8'hF0, 8'hF0);
        tick();
        vectors++;
        if (mem_read_valid !== 2'b01 || mem_write_valid !== 2'b10 || mem_read_address[7:0] !== 8'hFF
            || mem_write_address[15:8] !== 8'hF0 || mem_write_data[15:8] !== 8'hF0) begin
            miscompares++;
            $display("FAIL dual_issue got rv=%b wv=%b ra=%h wa=%h wd=%h want rv=01 wv=10 ra=ff wa=f0 wd=f0",
                     mem_read_valid, mem_write_valid, mem_read_address[7:0], mem_write_address[15:8], mem_write_data[15:8]);
        end
        mem_write_ready[1] = 1'b1;
        tick();
        mem_write_ready = '0;
        vectors++;
        if (req_write_ready !== 8'h02 || req_read_ready !== 8'h00 || mem_write_valid !== 2'b00 || mem_read_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL dual_write_done got wr=%b rr=%b wv=%b rv=%b want wr=00000010 rr=0 wv=00 rv=01",
                     req_write_ready, req_read_ready, mem_write_valid, mem_read_valid);
        end
        mem_read_ready[0] = 1'b1; mem_read_data[7:0] = 8'h5A;
        tick();
        mem_read_ready = '0;
        vectors++;
        if (req_read_ready !== 8'h01 || req_read_data[7:0] !== 8'h5A) begin
            miscompares++;
            $display("FAIL dual_read_done got rr=%b d=%h want rr=00000001 d=5a", req_read_ready, req_read_data[7:0]);
        end
        $display("dual_grant: ch0 read ff, ch1 write f0/f0");
    endtask

    task automatic test_contention();
        do_reset();
        rd_req(0, 1'b1, 8'h30); rd_req(3, 1'b1, 8'h33); rd_req(5, 1'b1, 8'h35);
        tick();
        vectors++;
        if (mem_read_valid !== 2'b11 || mem_read_address !== 16'h3330) begin
            miscompares++;
            $display("FAIL contend_first got v=%b a=%h want v=11 a=3330", mem_read_valid, mem_read_address);
        end
        mem_read_ready[0] = 1'b1; mem_read_data[7:0] = 8'hC0;
        tick();
        mem_read_ready = '0;
        rd_req(0, 1'b0, 8'h30);
        tick();
        // lane0 re-requests immediately; rr_ptr of 4 must still favour lane5
        rd_req(0, 1'b1, 8'h30);
        tick();
        vectors++;
        if (mem_read_valid !== 2'b11 || mem_read_address !== 16'h3335) begin
            miscompares++;
            $display("FAIL contend_lane5 got v=%b a=%h want v=11 a=3335", mem_read_valid, mem_read_address);
        end
        $display("contention: lanes 0,3 then 5");
    endtask

    task automatic test_fairness();
        logic [7:0] exp_addr;
        int         exp_lane;
        do_reset();
        wr_req(7, 1'b1, 8'h77, 8'h07);
        tick();
        rd_req(0, 1'b1, 8'h10); rd_req(1, 1'b1, 8'h11);
        tick();
        for (int r = 0; r < 4; r++) begin
            exp_lane = r % 2;
            exp_addr = 8'h10 + 8'(exp_lane);
            vectors++;
            if (mem_read_valid[1] !== 1'b1 || mem_read_address[15:8] !== exp_addr) begin
                miscompares++;
                $display("FAIL fair_round%0d got v=%b a=%h want v=1 a=%h", r, mem_read_valid[1], mem_read_address[15:8], exp_addr);
            end
            mem_read_ready[1] = 1'b1; mem_read_data[15:8] = 8'h50 + 8'(r);
            tick();
            mem_read_ready = '0;
            vectors++;
            if (req_read_ready[exp_lane] !== 1'b1 || req_read_data[exp_lane*8 +: 8] !== 8'h50 + 8'(r)) begin
                miscompares++;
                $display("FAIL fair_resp%0d got rdy=%b d=%h want rdy=1 d=%h", r, req_read_ready[exp_lane], req_read_data[exp_lane*8 +: 8], 8'h50 + 8'(r));
            end
            rd_req(exp_lane, 1'b0, exp_addr);
            tick();
            rd_req(exp_lane, 1'b1, exp_addr);
            tick();
            $display("fairness: round %0d served lane %0d", r, exp_lane);
        end
        vectors++;
        if (mem_write_valid !== 2'b01 || mem_write_address[7:0] !== 8'h77) begin
            miscompares++;
            $display("FAIL fair_ch0_hold got wv=%b a=%h want wv=01 a=77", mem_write_valid, mem_write_address[7:0]);
        end
    endtask

    task automatic test_same_lane();
        do_reset();
        rd_req(2, 1'b1, 8'h22);
        wr_req(2, 1'b1, 8'h2A, 8'h99);
        tick();
        vectors++;
        if (mem_read_valid !== 2'b01 || mem_write_valid !== 2'b00 || mem_read_address[7:0] !== 8'h22) begin
            miscompares++;
            $display("FAIL same_read_first got rv=%b wv=%b a=%h want rv=01 wv=00 a=22", mem_read_valid, mem_write_valid, mem_read_address[7:0]);
        end
        mem_read_ready[0] = 1'b1; mem_read_data[7:0] = 8'h12;
        tick();
        mem_read_ready = '0;
        rd_req(2, 1'b0, 8'h22);
        tick();
        vectors++;
        if (req_read_ready !== 8'h00 || mem_write_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL same_release got rr=%b wv=%b want rr=0 wv=00", req_read_ready, mem_write_valid);
        end
        tick();
        vectors++;
        if (mem_write_valid !== 2'b01 || mem_write_address[7:0] !== 8'h2A || mem_write_data[7:0] !== 8'h99) begin
            miscompares++;
            $display("FAIL same_write got wv=%b a=%h d=%h want wv=01 a=2a d=99", mem_write_valid, mem_write_address[7:0], mem_write_data[7:0]);
        end
        $display("same_lane: lane2 read then write");
    endtask

    task automatic test_early_drop();
        do_reset();
        rd_req(3, 1'b1, 8'h3C);
        tick();
        rd_req(3, 1'b0, 8'h3C);
        mem_read_ready[0] = 1'b1; mem_read_data[7:0] = 8'hE1;
        tick();
        mem_read_ready = '0;
        vectors++;
        if (req_read_ready !== 8'h08 || req_read_data[31:24] !== 8'hE1) begin
            miscompares++;
            $display("FAIL early_pulse got rr=%b d=%h want rr=00001000 d=e1", req_read_ready, req_read_data[31:24]);
        end
        tick();
        vectors++;
        if (req_read_ready !== 8'h00 || mem_read_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL early_end got rr=%b rv=%b want rr=0 rv=00", req_read_ready, mem_read_valid);
        end
        $display("early_drop: lane3 ready pulsed one cycle");
    endtask

    task automatic test_reset_mid();
        do_reset();
        rd_req(6, 1'b1, 8'h66);
        tick();
        vectors++;
        if (mem_read_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL mid_issue got rv=%b want 01", mem_read_valid);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (mem_read_valid !== 2'b00 || mem_read_address !== 16'h0000 || req_read_ready !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_clear got rv=%b a=%h rr=%b want all 0", mem_read_valid, mem_read_address, req_read_ready);
        end
        rd_req(6, 1'b0, 8'h00);
        tick();
        reset = 1'b0;
        mem_read_ready[0] = 1'b1; mem_read_data[7:0] = 8'h77;
        tick();
        mem_read_ready = '0;
        vectors++;
        if (req_read_ready !== 8'h00 || req_read_data !== 64'h0 || mem_read_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_stale got rr=%b d=%h rv=%b want all 0", req_read_ready, req_read_data, mem_read_valid);
        end
        rd_req(4, 1'b1, 8'h44);
        tick();
        vectors++;
        if (mem_read_valid !== 2'b01 || mem_read_address[7:0] !== 8'h44) begin
            miscompares++;
            $display("FAIL mid_new_issue got rv=%b a=%h want rv=01 a=44", mem_read_valid, mem_read_address[7:0]);
        end
        mem_read_ready[0] = 1'b1; mem_read_data[7:0] = 8'h4D;
        tick();
        mem_read_ready = '0;
        vectors++;
        if (req_read_ready !== 8'h10 || req_read_data[39:32] !== 8'h4D) begin
            miscompares++;
            $display("FAIL mid_new_resp got rr=%b d=%h want rr=00010000 d=4d", req_read_ready, req_read_data[39:32]);
        end
        $display("reset_mid: abandon then lane4 read 44 -> 4d");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_dual_grant();
        test_contention();
        test_fairness();
        test_same_lane();
        test_early_drop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
